pc_sequencer: RTL and testbench

Owns the fetch program counter and sequences it each cycle: sequential increment, taken-branch redirect, CALL redirect with return-address push, and RET redirect from an internal circular return-address stack (RAS). It sits between the EX stage and the instruction-fetch port. It resolves control transfers for the instruction currently in EX under the delayed-branch rule, and fully resolves RET, which the plain next-PC logic cannot.

---
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : EX-side control inputs and fetch-side outputs of the
//               program-counter sequencer, bundled as one port.
// Revision    : 1.0  initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int RAS_DEPTH = 8
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic          stall;
  logic          ex_valid;
  logic [15:0]   ex_pc;
  logic [15:0]   ex_instr;
  logic          branch;
  logic [15:0]   if_pc;
  logic          redirect;
  logic [CW-1:0] ras_count;
  logic          ras_ovf;
  logic          ras_unf;

  // Pipeline / EX-stage side: drives the instruction, observes fetch state.
  modport master (
    output stall, ex_valid, ex_pc, ex_instr, branch,
    input  if_pc, redirect, ras_count, ras_ovf, ras_unf
  );

  // Sequencer side.
  modport slave (
    input  stall, ex_valid, ex_pc, ex_instr, branch,
    output if_pc, redirect, ras_count, ras_ovf, ras_unf
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch program counter with sequential increment, taken-branch
//               and CALL redirects, and RET redirect from a circular
//               return-address stack with sticky overflow/underflow flags.
// Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          RAS_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_sequencer_if.slave bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_FULL = CW'(RAS_DEPTH);

  // Opcode values from the shared opcode header (B, CALL, RET).
  localparam logic [3:0] c_OP_B    = 4'h8;
  localparam logic [3:0] c_OP_CALL = 4'h9;
  localparam logic [3:0] c_OP_RET  = 4'hA;

  logic [15:0]   if_pc_q,    if_pc_d;
  logic          redirect_q, redirect_d;
  logic [PW-1:0] ptr_q,      ptr_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          ovf_q,      ovf_d;
  logic          unf_q,      unf_d;

  // Stack storage is not reset; occupancy alone decides what is valid.
  logic [15:0]   ras_mem_q [RAS_DEPTH];

  logic [3:0]    w_opcode;
  logic [15:0]   w_br_off;
  logic [PW-1:0] w_ptr_dec;
  logic          w_push;
  logic [15:0]   w_push_data;

  assign w_opcode  = bus.ex_instr[15:12];
  assign w_br_off  = {{8{bus.ex_instr[7]}}, bus.ex_instr[7:0]};
  assign w_ptr_dec = ptr_q - PW'(1);

  // Next-PC selection and stack bookkeeping; everything holds under stall.
  always_comb begin
    if_pc_d     = if_pc_q;
    redirect_d  = 1'b0;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    w_push      = 1'b0;
    // Return point is past the delay slot.
    w_push_data = bus.ex_pc + 16'd2;

    if (!bus.stall) begin
      if_pc_d = if_pc_q + 16'd1;
      if (bus.ex_valid) begin
        case (w_opcode)
          c_OP_B: begin
            if (bus.branch) begin
              if_pc_d    = bus.ex_pc + 16'd2 + w_br_off;
              redirect_d = 1'b1;
            end
          end
          c_OP_CALL: begin
            if_pc_d    = {bus.ex_pc[15:12], bus.ex_instr[11:0]};
            redirect_d = 1'b1;
            w_push     = 1'b1;
            ptr_d      = ptr_q + PW'(1);
            // When full the write at ptr overwrites the oldest entry.
            if (cnt_q == c_FULL) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          c_OP_RET: begin
            redirect_d = 1'b1;
            if (cnt_q == '0) begin
              if_pc_d = RESET_PC;
              unf_d   = 1'b1;
            end else begin
              if_pc_d = ras_mem_q[w_ptr_dec];
              ptr_d   = w_ptr_dec;
              cnt_d   = cnt_q - CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Architectural state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pc_q    <= RESET_PC;
      redirect_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      if_pc_q    <= if_pc_d;
      redirect_q <= redirect_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Return-address write port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      ras_mem_q[ptr_q] <= w_push_data;
    end
  end

  assign bus.if_pc     = if_pc_q;
  assign bus.redirect  = redirect_q;
  assign bus.ras_count = cnt_q;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: directed scenarios plus
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [15:0] c_RESET_PC  = 16'h0100;
  localparam int          c_DEPTH     = 8;
  localparam logic [3:0]  c_OP_B      = 4'h8;
  localparam logic [3:0]  c_OP_CALL   = 4'h9;
  localparam logic [3:0]  c_OP_RET    = 4'hA;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_sequencer_if #(.RAS_DEPTH(c_DEPTH)) bus ();

  pc_sequencer #(
    .RESET_PC (c_RESET_PC),
    .RAS_DEPTH(c_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: program counter plus a bounded LIFO of return addresses.
  logic [15:0] m_pc;
  logic        m_redirect;
  logic        m_ovf;
  logic        m_unf;
  logic [15:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc       = c_RESET_PC;
    m_redirect = 1'b0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step(input logic st, input logic v, input logic [15:0] pc,
                            input logic [15:0] ins, input logic br);
    int off;
    m_redirect = 1'b0;
    if (st) return;
    if (v && ins[15:12] == c_OP_B && br) begin
      off        = $signed(ins[7:0]);
      m_pc       = 16'(int'(pc) + 2 + off);
      m_redirect = 1'b1;
    end else if (v && ins[15:12] == c_OP_CALL) begin
      m_ras.push_back(16'(int'(pc) + 2));
      if (m_ras.size() > c_DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_pc       = {pc[15:12], ins[11:0]};
      m_redirect = 1'b1;
    end else if (v && ins[15:12] == c_OP_RET) begin
      if (m_ras.size() == 0) begin
        m_pc  = c_RESET_PC;
        m_unf = 1'b1;
      end else begin
        m_pc = m_ras.pop_back();
      end
      m_redirect = 1'b1;
    end else begin
      m_pc = 16'(int'(m_pc) + 1);
    end
  endtask

  task automatic check_all();
    check("if_pc",     32'(bus.if_pc),     32'(m_pc));
    check("redirect",  32'(bus.redirect),  32'(m_redirect));
    check("ras_count", 32'(bus.ras_count), 32'(m_ras.size()));
    check("ras_ovf",   32'(bus.ras_ovf),   32'(m_ovf));
    check("ras_unf",   32'(bus.ras_unf),   32'(m_unf));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic cycle(input logic st, input logic v, input logic [15:0] pc,
                       input logic [15:0] ins, input logic br);
    bus.stall    = st;
    bus.ex_valid = v;
    bus.ex_pc    = pc;
    bus.ex_instr = ins;
    bus.branch   = br;
    @(posedge clk);
    model_step(st, v, pc, ins, br);
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  initial begin
    logic [15:0] r_ret_pc;
    logic [3:0]  r_op;
    bus.stall    = 1'b0;
    bus.ex_valid = 1'b0;
    bus.ex_pc    = '0;
    bus.ex_instr = '0;
    bus.branch   = 1'b0;
    rst_n        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", 32'(bus.if_pc), 32'(c_RESET_PC));
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running after reset.
    for (int i = 1; i <= 3; i++) begin
      idle();
      check("seq_pc", 32'(bus.if_pc), 32'(c_RESET_PC) + 32'(i));
    end

    // Taken / not-taken branch with negative offset.
    cycle(1'b0, 1'b1, 16'h0010, {c_OP_B, 4'h0, 8'hFC}, 1'b1);
    check("b_taken", 32'(bus.if_pc), 32'h000E);
    check("b_redir", 32'(bus.redirect), 32'd1);
    cycle(1'b0, 1'b1, 16'h0010, {c_OP_B, 4'h0, 8'hFC}, 1'b0);
    check("b_not_taken", 32'(bus.if_pc), 32'h000F);

    // CALL then RET.
    cycle(1'b0, 1'b1, 16'h3020, {c_OP_CALL, 12'h456}, 1'b0);
    check("call_tgt", 32'(bus.if_pc), 32'h3456);
    check("call_cnt", 32'(bus.ras_count), 32'd1);
    idle();
    idle();
    cycle(1'b0, 1'b1, 16'h3458, {c_OP_RET, 12'h000}, 1'b0);
    check("ret_tgt", 32'(bus.if_pc), 32'h3022);
    check("ret_cnt", 32'(bus.ras_count), 32'd0);

    // Nine nested CALLs overflow an eight-deep stack.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, 16'h1000 + 16'(i * 16), {c_OP_CALL, 12'(12'h200 + i)}, 1'b0);
    end
    check("ovf_flag", 32'(bus.ras_ovf), 32'd1);
    check("ovf_cnt",  32'(bus.ras_count), 32'd8);
    for (int i = 8; i >= 1; i--) begin
      cycle(1'b0, 1'b1, 16'h2000, {c_OP_RET, 12'h000}, 1'b0);
      r_ret_pc = 16'h1000 + 16'(i * 16) + 16'd2;
      check("lifo_ret", 32'(bus.if_pc), 32'(r_ret_pc));
    end
    cycle(1'b0, 1'b1, 16'h2000, {c_OP_RET, 12'h000}, 1'b0);
    check("unf_pc",   32'(bus.if_pc), 32'(c_RESET_PC));
    check("unf_flag", 32'(bus.ras_unf), 32'd1);
    check("unf_cnt",  32'(bus.ras_count), 32'd0);

    // CALL held under stall: frozen, then exactly one push on release.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 16'h5000, {c_OP_CALL, 12'h777}, 1'b0);
      check("stall_pc",  32'(bus.if_pc), 32'(c_RESET_PC));
      check("stall_cnt", 32'(bus.ras_count), 32'd0);
    end
    cycle(1'b0, 1'b1, 16'h5000, {c_OP_CALL, 12'h777}, 1'b0);
    check("rel_pc",  32'(bus.if_pc), 32'h5777);
    check("rel_cnt", 32'(bus.ras_count), 32'd1);
    idle();
    check("rel_once", 32'(bus.ras_count), 32'd1);
    check("rel_redir_drop", 32'(bus.redirect), 32'd0);

    // Address wrap: forward branch past FFFF and sequential FFFF -> 0000.
    cycle(1'b0, 1'b1, 16'hFFF0, {c_OP_B, 4'h0, 8'h7F}, 1'b1);
    check("wrap_b", 32'(bus.if_pc), 32'h0071);
    cycle(1'b0, 1'b1, 16'hF000, {c_OP_CALL, 12'hFFF}, 1'b0);
    check("at_ffff", 32'(bus.if_pc), 32'hFFFF);
    idle();
    check("wrap_seq", 32'(bus.if_pc), 32'h0000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    r_op = c_OP_B;
        2:       r_op = c_OP_CALL;
        3:       r_op = c_OP_RET;
        default: r_op = 4'($urandom);
      endcase
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), 16'($urandom),
            {r_op, 12'($urandom)}, ($urandom_range(0, 1) == 1));
    end

    // Asynchronous reset mid-cycle: takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_pc", 32'(bus.if_pc), 32'(c_RESET_PC));
    check_all();
    bus.ex_valid = 1'b0;
    bus.stall    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("post_rst_seq", 32'(bus.if_pc), 32'(c_RESET_PC) + 32'd1);
    cycle(1'b0, 1'b1, 16'h4000, {c_OP_RET, 12'h000}, 1'b0);
    check("post_rst_unf", 32'(bus.ras_unf), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
